sweep_controller: RTL and testbench

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

---
 rtl/sweep_pkg.sv | 29 ++
 rtl/sweep_dwell_timer.sv | 28 ++
 rtl/sweep_controller.sv | 166 ++++++++++++++++
 tb/tb_sweep_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the step-size sweep controller and its dwell timer.
package sweep_pkg;

    typedef enum logic [1:0] {
        SWEEP_SINGLE = 2'd0,
        SWEEP_SAW    = 2'd1,
        SWEEP_TRI    = 2'd2
    } mode_e;

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    typedef enum logic {
        DirUp,
        DirDown
    } dir_e;

    // Encoding 3 is unassigned and runs as a single sweep.
    function automatic mode_e to_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SWEEP_SAW;
            2'd2:    return SWEEP_TRI;
            default: return SWEEP_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: loads a hold length, counts down while enabled, flags the final cycle.
module sweep_dwell_timer #(
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_res_n,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_load_val,
    input  logic                   i_count,
    output logic                   o_expire
);

    logic [DWELL_WIDTH-1:0] r_cnt;

    // Loaded with (hold length - 1), so zero marks the last held cycle.
    assign o_expire = i_count && (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sweep_controller.sv
// Sweeps signal_generator step_size between two endpoints in single, sawtooth or triangle mode,
// holding each value for a programmable dwell.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 8,
    parameter int unsigned PRECISION    = 16,
    parameter int unsigned DWELL_WIDTH  = 16
) (
    input  logic                                i_clk,
    input  logic                                i_res_n,
    input  logic                                i_start,
    input  logic                                i_abort,
    input  logic [ADDRESS_SIZE+PRECISION-1:0]   i_start_step,
    input  logic [ADDRESS_SIZE+PRECISION-1:0]   i_stop_step,
    input  logic [ADDRESS_SIZE+PRECISION-1:0]   i_delta,
    input  logic [DWELL_WIDTH-1:0]              i_dwell,
    input  logic [1:0]                          i_mode,
    output logic [ADDRESS_SIZE+PRECISION-1:0]   o_step_size,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_wrap
);

    localparam int unsigned SW = ADDRESS_SIZE + PRECISION;

    state_e                 r_state;
    dir_e                   r_dir;
    mode_e                  r_mode;
    logic [SW-1:0]          r_start;
    logic [SW-1:0]          r_lo;
    logic [SW-1:0]          r_hi;
    logic [SW-1:0]          r_delta;
    logic [DWELL_WIDTH-1:0] r_dwell_m1;
    logic [SW-1:0]          r_step;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_wrap;

    logic                   w_accept;
    logic                   w_expire;
    logic                   w_load;
    logic [DWELL_WIDTH-1:0] w_load_val;
    logic [DWELL_WIDTH-1:0] w_in_dwell_m1;
    logic [SW-1:0]          w_target;
    logic [SW-1:0]          w_other;
    logic                   w_at_end;
    logic [SW-1:0]          w_next_fwd;
    logic [SW-1:0]          w_next_rev;
    dir_e                   w_dir_rev;

    // One step toward t; the SW+1-bit sum/difference lets the endpoint clamp catch any overshoot.
    function automatic logic [SW-1:0] f_advance(input logic [SW-1:0] v, input logic [SW-1:0] d,
                                                input logic [SW-1:0] t, input dir_e dir);
        logic [SW:0] w_sum;
        if (d == '0) return t;
        if (dir == DirUp) begin
            w_sum = {1'b0, v} + {1'b0, d};
            return (w_sum >= {1'b0, t}) ? t : w_sum[SW-1:0];
        end
        w_sum = {1'b0, v} - {1'b0, d};
        return (w_sum[SW] || (w_sum[SW-1:0] <= t)) ? t : w_sum[SW-1:0];
    endfunction

    always_comb begin
        w_accept      = (r_state == StIdle) && i_start && !i_abort;
        w_in_dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
        w_load        = w_accept || ((r_state == StHold) && w_expire && !i_abort);
        w_load_val    = (r_state == StIdle) ? w_in_dwell_m1 : r_dwell_m1;
        w_dir_rev     = (r_dir == DirUp) ? DirDown : DirUp;
        w_target      = (r_dir == DirUp) ? r_hi : r_lo;
        w_other       = (r_dir == DirUp) ? r_lo : r_hi;
        w_at_end      = (r_step == w_target);
        w_next_fwd    = f_advance(r_step, r_delta, w_target, r_dir);
        w_next_rev    = f_advance(r_step, r_delta, w_other, w_dir_rev);
    end

    sweep_dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .i_clk     (i_clk),
        .i_res_n   (i_res_n),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .i_count   (r_state == StHold),
        .o_expire  (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state    <= StIdle;
            r_dir      <= DirUp;
            r_mode     <= SWEEP_SINGLE;
            r_start    <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_delta    <= '0;
            r_dwell_m1 <= '0;
            r_step     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_mode     <= to_mode(i_mode);
                        r_start    <= i_start_step;
                        r_delta    <= i_delta;
                        r_dwell_m1 <= w_in_dwell_m1;
                        r_step     <= i_start_step;
                        r_busy     <= 1'b1;
                        r_state    <= StHold;
                        if (i_start_step <= i_stop_step) begin
                            r_dir <= DirUp;
                            r_lo  <= i_start_step;
                            r_hi  <= i_stop_step;
                        end else begin
                            r_dir <= DirDown;
                            r_lo  <= i_stop_step;
                            r_hi  <= i_start_step;
                        end
                    end
                end
                StHold: begin
                    if (i_abort) begin
                        r_state <= StIdle;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_expire) begin
                        if (!w_at_end) begin
                            r_step <= w_next_fwd;
                            r_wrap <= (r_mode == SWEEP_TRI) && (w_next_fwd == r_start);
                        end else begin
                            unique case (r_mode)
                                SWEEP_SAW: begin
                                    r_step <= r_start;
                                    r_wrap <= 1'b1;
                                end
                                // Turn around immediately so the endpoint is held only once.
                                SWEEP_TRI: begin
                                    r_dir  <= w_dir_rev;
                                    r_step <= w_next_rev;
                                    r_wrap <= (w_next_rev == r_start);
                                end
                                default: begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= StIdle;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign o_step_size = r_step;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller: directed sweeps push per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_sweep_controller;

    logic        i_clk = 1'b0;
    logic        i_res_n;
    logic        i_start;
    logic        i_abort;
    logic [23:0] i_start_step;
    logic [23:0] i_stop_step;
    logic [23:0] i_delta;
    logic [15:0] i_dwell;
    logic [1:0]  i_mode;
    logic [23:0] o_step_size;
    logic        o_busy;
    logic        o_done;
    logic        o_wrap;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          sb_cyc[$];
    logic [26:0] sb_val[$];
    string       sb_tag[$];
    logic [26:0] w_obs;

    sweep_controller #(
        .ADDRESS_SIZE(8),
        .PRECISION   (16),
        .DWELL_WIDTH (16)
    ) dut (
        .i_clk       (i_clk),
        .i_res_n     (i_res_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_start_step(i_start_step),
        .i_stop_step (i_stop_step),
        .i_delta     (i_delta),
        .i_dwell     (i_dwell),
        .i_mode      (i_mode),
        .o_step_size (o_step_size),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_wrap      (o_wrap)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;
    assign w_obs = {o_step_size, o_busy, o_done, o_wrap};

    task automatic check(input string tag, input int c, input logic [26:0] got,
                         input logic [26:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got step=%h busy/done/wrap=%b, required step=%h busy/done/wrap=%b",
                      tag, c, got[26:3], got[2:0], want[26:3], want[2:0]);
    endtask

    always @(negedge i_clk) begin
        while (sb_cyc.size() > 0 && sb_cyc[0] <= cyc) begin
            if (sb_cyc[0] < cyc) begin
                n_checks++;
                $display("FAIL %s cycle %0d: got no comparison, required one", sb_tag[0], sb_cyc[0]);
            end else begin
                check(sb_tag[0], cyc, w_obs, sb_val[0]);
            end
            void'(sb_cyc.pop_front());
            void'(sb_val.pop_front());
            void'(sb_tag.pop_front());
        end
    end

    task automatic expect_at(input int c, input logic [23:0] step, input logic busy,
                             input logic done, input logic wrap, input string tag);
        sb_cyc.push_back(c);
        sb_val.push_back({step, busy, done, wrap});
        sb_tag.push_back(tag);
    endtask

    task automatic launch(input logic [1:0] mode, input logic [23:0] st, input logic [23:0] sp,
                          input logic [23:0] d, input logic [15:0] dw, output int c0);
        @(negedge i_clk);
        i_mode = mode;
        i_start_step = st;
        i_stop_step = sp;
        i_delta = d;
        i_dwell = dw;
        i_start = 1'b1;
        c0 = cyc;
    endtask

    // Drop start and scramble config; a latched sweep must not notice.
    task automatic settle();
        @(negedge i_clk);
        i_start = 1'b0;
        i_start_step = 24'hABCDEF;
        i_stop_step = 24'h000001;
        i_delta = 24'h000007;
        i_dwell = 16'd9;
        i_mode = 2'd1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic single_ref(input string tag);
        int c0;
        launch(2'd0, 24'h010000, 24'h040000, 24'h010000, 16'd2, c0);
        for (int k = 1; k <= 8; k++) expect_at(c0 + k, 24'h010000 * ((k + 1) / 2), 1, 0, 0, tag);
        expect_at(c0 + 9, 24'h040000, 0, 1, 0, {tag, "_done"});
        expect_at(c0 + 10, 24'h040000, 0, 0, 0, {tag, "_idle"});
        settle();
        wait_cyc(c0 + 3);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_cyc(c0 + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
        logic [23:0] tri_seq [9];
        tri_seq = '{24'd1, 24'd2, 24'd3, 24'd2, 24'd1, 24'd2, 24'd3, 24'd2, 24'd1};
        i_res_n = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_start_step = '0;
        i_stop_step = '0;
        i_delta = '0;
        i_dwell = '0;
        i_mode = '0;
        #13;
        check("reset", cyc, w_obs, 27'd0);
        #9;
        i_res_n = 1'b1;

        single_ref("single");

        launch(2'd0, 24'h000000, 24'h025000, 24'h010000, 16'd1, c0);
        expect_at(c0 + 1, 24'h000000, 1, 0, 0, "sat_up");
        expect_at(c0 + 2, 24'h010000, 1, 0, 0, "sat_up");
        expect_at(c0 + 3, 24'h020000, 1, 0, 0, "sat_up");
        expect_at(c0 + 4, 24'h025000, 1, 0, 0, "sat_up_clamp");
        expect_at(c0 + 5, 24'h025000, 0, 1, 0, "sat_up_done");
        settle();
        wait_cyc(c0 + 5);

        launch(2'd0, 24'h030000, 24'h010000, 24'h010000, 16'd0, c0);
        expect_at(c0 + 1, 24'h030000, 1, 0, 0, "down");
        expect_at(c0 + 2, 24'h020000, 1, 0, 0, "down");
        expect_at(c0 + 3, 24'h010000, 1, 0, 0, "down");
        expect_at(c0 + 4, 24'h010000, 0, 1, 0, "down_done");
        settle();
        wait_cyc(c0 + 4);

        launch(2'd0, 24'hFF0000, 24'hFFFFFF, 24'h800000, 16'd1, c0);
        expect_at(c0 + 1, 24'hFF0000, 1, 0, 0, "ovf");
        expect_at(c0 + 2, 24'hFFFFFF, 1, 0, 0, "ovf_clamp");
        expect_at(c0 + 3, 24'hFFFFFF, 0, 1, 0, "ovf_done");
        settle();
        wait_cyc(c0 + 3);

        launch(2'd3, 24'h000005, 24'h000005, 24'h000010, 16'd3, c0);
        for (int k = 1; k <= 3; k++) expect_at(c0 + k, 24'h000005, 1, 0, 0, "equal_ends");
        expect_at(c0 + 4, 24'h000005, 0, 1, 0, "equal_ends_done");
        settle();
        wait_cyc(c0 + 4);

        launch(2'd2, 24'd1, 24'd3, 24'd1, 16'd1, c0);
        for (int k = 1; k <= 9; k++)
            expect_at(c0 + k, tri_seq[k-1], 1, 0, (k == 5 || k == 9), "triangle");
        settle();
        wait_cyc(c0 + 9);
        i_abort = 1'b1;
        expect_at(c0 + 10, 24'd0, 0, 0, 0, "tri_abort");
        @(negedge i_clk);
        i_abort = 1'b0;
        expect_at(c0 + 11, 24'd0, 0, 0, 0, "tri_abort_idle");
        wait_cyc(c0 + 11);

        launch(2'd1, 24'h000010, 24'h000030, 24'h000010, 16'd1, c0);
        expect_at(c0 + 1, 24'h000010, 1, 0, 0, "saw");
        expect_at(c0 + 2, 24'h000020, 1, 0, 0, "saw");
        expect_at(c0 + 3, 24'h000030, 1, 0, 0, "saw");
        expect_at(c0 + 4, 24'h000010, 1, 0, 1, "saw_wrap");
        expect_at(c0 + 5, 24'h000020, 1, 0, 0, "saw");
        settle();
        wait_cyc(c0 + 5);
        i_abort = 1'b1;
        i_start = 1'b1;
        expect_at(c0 + 6, 24'd0, 0, 0, 0, "abort_over_start");
        @(negedge i_clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        expect_at(c0 + 7, 24'd0, 0, 0, 0, "abort_no_restart");
        wait_cyc(c0 + 7);

        launch(2'd0, 24'h010000, 24'h040000, 24'h010000, 16'd2, c0);
        for (int k = 1; k <= 3; k++) expect_at(c0 + k, 24'h010000 * ((k + 1) / 2), 1, 0, 0, "pre_reset");
        settle();
        wait_cyc(c0 + 4);
        #2;
        i_res_n = 1'b0;
        #1;
        check("async_reset", cyc, w_obs, 27'd0);
        #1;
        i_res_n = 1'b1;
        single_ref("after_reset");

        repeat (3) @(negedge i_clk);
        while (sb_cyc.size() > 0) begin
            n_checks++;
            $display("FAIL %s cycle %0d: got no comparison, required one", sb_tag[0], sb_cyc[0]);
            void'(sb_cyc.pop_front());
            void'(sb_val.pop_front());
            void'(sb_tag.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
